// File: rtl/alu_exec.sv
// Execute stage: result = dst OP src with registered result/flags and a one-cycle done strobe.
// Single-cycle ops finish two edges after start; MUL is an iterative shift-add taking WIDTH steps.
module alu_exec #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OpAdd = 4'd1;
  localparam logic [3:0] OpSub = 4'd2;
  localparam logic [3:0] OpAnd = 4'd3;
  localparam logic [3:0] OpOr  = 4'd4;
  localparam logic [3:0] OpXor = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpMul = 4'd8;

  typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;        // latched dst
  logic [WIDTH-1:0]     b_q, b_d;        // latched src; shifted right as MUL multiplier
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     exec_res;
  logic                 exec_c, exec_v, exec_nop;
  logic [WIDTH:0]       shl_w, shr_w;
  logic [2*WIDTH-1:0]   prod_step;

  // Wide shifts expose the last bit shifted out in the extra position.
  assign shl_w     = {1'b0, a_q} << b_q[3:0];
  assign shr_w     = {a_q, 1'b0} >> b_q[3:0];
  assign prod_step = prod_q + (b_q[0] ? mcand_q : '0);

  // Single-cycle datapath on the latched operands.
  always_comb begin
    exec_res = a_q;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    exec_nop = 1'b0;
    case (op_q)
      OpAdd: begin
        {exec_c, exec_res} = {1'b0, a_q} + {1'b0, b_q};
        exec_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (exec_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        exec_res = a_q - b_q;
        exec_c   = (a_q < b_q);
        exec_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (exec_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpAnd: exec_res = a_q & b_q;
      OpOr:  exec_res = a_q | b_q;
      OpXor: exec_res = a_q ^ b_q;
      OpShl: {exec_c, exec_res} = shl_w;
      OpShr: {exec_res, exec_c} = shr_w;
      // Opcode 0, 9-15 and MUL with MUL_EN=0: result=dst, flags kept.
      default: exec_nop = 1'b1;
    endcase
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d = op;
          a_d  = dst;
          b_d  = src;
          if (MUL_EN && (op == OpMul)) begin
            state_d = StMul;
            cnt_d   = '0;
            prod_d  = '0;
            mcand_d = {{WIDTH{1'b0}}, dst};
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        result_d = exec_res;
        if (!exec_nop) begin
          flags_d = {exec_v, exec_c, exec_res[WIDTH-1], ~|exec_res};
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StMul: begin
        prod_d  = prod_step;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          result_d = prod_step[WIDTH-1:0];
          flags_d  = {1'b0, |prod_step[2*WIDTH-1:WIDTH], prod_step[WIDTH-1],
                      ~|prod_step[WIDTH-1:0]};
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // The done cycle is spent in StIdle, so busy and done are never high together.
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes model expectations, negedge monitor pops on done.
module tb_alu_exec;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] src = '0;
  logic [W-1:0] dst = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src    (src),
    .dst    (dst),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           due;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_flags = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic; flags persist across NOPs.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] d, input logic [W-1:0] s,
                                output logic [W-1:0] r, output logic [3:0] f);
    int          n   = int'(s[3:0]);
    int          sd  = int'($signed(d));
    int          ss  = int'($signed(s));
    int          sv  = 0;
    longint      p   = 0;
    logic        c   = 1'b0;
    logic        v   = 1'b0;
    bit          nop = 1'b0;
    r = d;
    case (o)
      4'd1: begin
        p = longint'(d) + longint'(s);
        r = p[W-1:0];
        c = (p > 65535);
        sv = sd + ss;
        v = (sv > 32767) || (sv < -32768);
      end
      4'd2: begin
        r = d - s;
        c = (d < s);
        sv = sd - ss;
        v = (sv > 32767) || (sv < -32768);
      end
      4'd3: r = d & s;
      4'd4: r = d | s;
      4'd5: r = d ^ s;
      4'd6: begin
        r = d << n;
        c = (n != 0) && d[W-n];
      end
      4'd7: begin
        r = d >> n;
        c = (n != 0) && d[n-1];
      end
      4'd8: begin
        p = longint'(d) * longint'(s);
        r = p[W-1:0];
        c = ((p >> 16) != 0);
      end
      default: nop = 1'b1;
    endcase
    if (nop) f = model_flags;
    else     f = {v, c, r[W-1], (r == '0)};
    model_flags = f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for idle, drives one start cycle, and queues the expected writeback.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] d, input logic [W-1:0] s,
                       input bit directed, input logic [W-1:0] xr, input logic [3:0] xf);
    int           g = 0;
    logic [W-1:0] mr;
    logic [3:0]   mf;
    exp_t         e;
    while (busy && g < 100) begin
      step();
      g++;
    end
    chk("idle_before_issue", 32'(busy), 32'd0);
    op    = o;
    dst   = d;
    src   = s;
    start = 1'b1;
    model(o, d, s, mr, mf);
    e.res = directed ? xr : mr;
    e.flg = directed ? xf : mf;
    e.due = cyc + ((o == 4'd8) ? (W + 1) : 2);
    sbq.push_back(e);
    step();
    start = 1'b0;
    op    = 4'($urandom);
    dst   = 16'($urandom);
    src   = 16'($urandom);
  endtask

  // One cycle of operand churn; start is raised only while busy, so it must be ignored.
  task automatic noise(input bit force_start);
    start = busy && (force_start || ($urandom_range(0, 1) == 1));
    op    = 4'($urandom);
    dst   = 16'($urandom);
    src   = 16'($urandom);
    step();
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: every done must match the oldest pending expectation at the expected cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("done_busy_excl", 32'(done & busy), 32'd0);
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("result", 32'(result), 32'(mon_e.res));
          chk("flags", 32'(flags), 32'(mon_e.flg));
          chk("done_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end
    end else begin
      chk("done_in_reset", 32'(done), 32'd0);
    end
  end

  initial begin
    int g;
    // Power-on reset.
    rst = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst = 1'b1;
    step();

    // ADD signed overflow, then NOP and opcode 12 keep flags.
    issue(4'd1, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1010);
    issue(4'd0, 16'h1234, 16'h5678, 1'b1, 16'h1234, 4'b1010);
    issue(4'd12, 16'hABCD, 16'h0000, 1'b1, 16'hABCD, 4'b1010);

    // SUB zero and borrow.
    issue(4'd2, 16'd5, 16'd5, 1'b1, 16'h0000, 4'b0001);
    issue(4'd2, 16'd0, 16'd1, 1'b1, 16'hFFFF, 4'b0110);

    // Shifts with carry-out and zero shift.
    issue(4'd6, 16'h8001, 16'd1, 1'b1, 16'h0002, 4'b0100);
    issue(4'd7, 16'h0003, 16'd0, 1'b1, 16'h0003, 4'b0000);

    // MUL with overflow into the high half; starts during busy are dropped.
    issue(4'd8, 16'd300, 16'd300, 1'b1, 16'h5F90, 4'b0100);
    repeat (5) noise(1'b1);

    // Reset in the middle of a MUL: no done may follow.
    issue(4'd8, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 4'b0000);
    repeat (4) noise(1'b1);
    rst = 1'b0;
    sbq.delete();
    model_flags = '0;
    repeat (3) step();
    chk("midmul_rst_busy", 32'(busy), 32'd0);
    chk("midmul_rst_done", 32'(done), 32'd0);
    chk("midmul_rst_result", 32'(result), 32'd0);
    chk("midmul_rst_flags", 32'(flags), 32'd0);
    rst = 1'b1;
    repeat (20) noise(1'b0);

    // Randomized traffic, including back-to-back starts in the done cycle.
    for (int i = 0; i < 80; i++) begin
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), 1'b0, 16'h0000, 4'b0000);
      repeat ($urandom_range(0, 2)) noise(1'b0);
    end

    g = 0;
    while (sbq.size() != 0 && g < 200) begin
      step();
      g++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
